mstage_lsu: RTL and testbench

Memory-access stage sitting between the execute stage and the writeback-stage bus. It accepts one instruction per valid/ready handshake from E and issues at most one load/store on a request/response data-memory port. Loads are aligned and sign- or zero-extended; misaligned accesses are detected. Every result leaves on a valid/ready handshake toward the writeback bus, together with the registered pass-through control bundle.

---
 rtl/mstage_lsu_pkg.sv | 35 +++
 rtl/mstage_lsu_if.sv | 24 ++
 rtl/mstage_lsu_align.sv | 52 +++++
 rtl/mstage_lsu.sv | 107 ++++++++++
 tb/tb_mstage_lsu.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mstage_lsu_pkg.sv
// Shared types and encodings for the memory-access stage.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] FN_B  = 3'b000;
    localparam logic [2:0] FN_H  = 3'b001;
    localparam logic [2:0] FN_W  = 3'b010;
    localparam logic [2:0] FN_BU = 3'b100;
    localparam logic [2:0] FN_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    // Stores only know SB/SH/SW; loads also have the unsigned forms.
    // Anything unrecognised falls back to a full word.
    function automatic size_t acc_size(input logic [2:0] f3, input logic is_store);
        size_t sz;
        sz = SZ_W;
        if (f3 == FN_B || (!is_store && f3 == FN_BU))
            sz = SZ_B;
        else if (f3 == FN_H || (!is_store && f3 == FN_HU))
            sz = SZ_H;
        return sz;
    endfunction

endpackage

// File: rtl/mstage_lsu_if.sv
// Request/response data-memory port between the M stage and memory.
interface mstage_lsu_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic        mem_resp_ready;
    logic [31:0] mem_resp_rdata;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        output mem_resp_ready,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        input  mem_resp_ready,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata
    );
endinterface

// File: rtl/mstage_lsu_align.sv
// Combinational byte-lane logic: store strobes/data, misalign check, load extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [31:0] wsrc,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic        misalign,
    output logic [31:0] ldata
);
    size_t       sz;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign sz     = acc_size(funct3, is_store);
    assign byte_v = rdata[{off, 3'b000} +: 8];
    assign half_v = rdata[{off[1], 4'b0000} +: 16];

    always_comb begin
        wstrb    = 4'b1111;
        wdata    = wsrc;
        misalign = |off;
        case (sz)
            SZ_B: begin
                wstrb    = 4'b0001 << off;
                wdata    = {4{wsrc[7:0]}};
                misalign = 1'b0;
            end
            SZ_H: begin
                wstrb    = 4'b0011 << {off[1], 1'b0};
                wdata    = {2{wsrc[15:0]}};
                misalign = off[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        ldata = rdata;
        case (funct3)
            FN_B:    ldata = {{24{byte_v[7]}}, byte_v};
            FN_BU:   ldata = {24'd0, byte_v};
            FN_H:    ldata = {{16{half_v[15]}}, half_v};
            FN_HU:   ldata = {16'd0, half_v};
            default: ;
        endcase
    end
endmodule

// File: rtl/mstage_lsu.sv
// M stage: one instruction at a time, optional single memory transaction, registered result.
module mstage_lsu
    import lsu_pkg::*;
#(
    parameter int PASS_W = 150
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       ALU_resultE,
    input  logic [31:0]       src2E,
    input  logic              mem_renE,
    input  logic              mem_wenE,
    input  logic [2:0]        funct3E,
    input  logic [PASS_W-1:0] passE,
    mstage_lsu_if.master      mem,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [31:0]       mdataM,
    output logic [31:0]       ALU_resultM,
    output logic [31:0]       src2M,
    output logic [PASS_W-1:0] passM,
    output logic              misalignM
);
    state_t      state, state_nxt;
    logic        ren_q, wen_q;
    logic [2:0]  f3_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;

    logic        in_idle, accept, is_mem_e;
    logic [3:0]  a_wstrb;
    logic [31:0] a_wdata, a_ldata;
    logic        a_mis;

    assign in_idle  = (state == IDLE);
    assign accept   = in_idle && s_valid;
    assign is_mem_e = mem_renE || mem_wenE;

    // Shared aligner: sees E inputs while idle, the captured op afterwards.
    lsu_align u_align (
        .off      (in_idle ? ALU_resultE[1:0] : ALU_resultM[1:0]),
        .funct3   (in_idle ? funct3E : f3_q),
        .is_store (in_idle ? mem_wenE : wen_q),
        .wsrc     (src2E),
        .rdata    (mem.mem_resp_rdata),
        .wstrb    (a_wstrb),
        .wdata    (a_wdata),
        .misalign (a_mis),
        .ldata    (a_ldata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (s_valid) state_nxt = (!is_mem_e || a_mis) ? DONE : REQ;
            REQ:  if (mem.mem_req_ready) state_nxt = RESP;
            RESP: if (mem.mem_resp_valid) state_nxt = DONE;
            DONE: if (m_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign s_ready            = in_idle;
    assign mem.mem_req_valid  = (state == REQ);
    assign mem.mem_resp_ready = (state == RESP);
    assign m_valid            = (state == DONE);

    assign mem.mem_req_addr  = {ALU_resultM[31:2], 2'b00};
    assign mem.mem_req_wen   = wen_q;
    assign mem.mem_req_wstrb = wstrb_q;
    assign mem.mem_req_wdata = wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALU_resultM <= '0;
            src2M       <= '0;
            passM       <= '0;
            mdataM      <= '0;
            misalignM   <= 1'b0;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
            f3_q        <= '0;
            wstrb_q     <= '0;
            wdata_q     <= '0;
        end else if (accept) begin
            ALU_resultM <= ALU_resultE;
            src2M       <= src2E;
            passM       <= passE;
            mdataM      <= '0;
            misalignM   <= is_mem_e && a_mis;
            ren_q       <= mem_renE;
            wen_q       <= mem_wenE;
            f3_q        <= funct3E;
            wstrb_q     <= mem_wenE ? a_wstrb : 4'b0000;
            wdata_q     <= mem_wenE ? a_wdata : 32'd0;
        end else if (state == RESP && mem.mem_resp_valid && ren_q) begin
            mdataM      <= a_ldata;
        end
    end
endmodule

// File: tb/tb_mstage_lsu.sv
// Randomised self-checking bench for mstage_lsu against a byte-arithmetic reference model.
module tb_mstage_lsu;
    localparam int PW = 150;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [31:0]   ALU_resultE = '0, src2E = '0;
    logic          mem_renE = 1'b0, mem_wenE = 1'b0;
    logic [2:0]    funct3E = '0;
    logic [PW-1:0] passE = '0;
    logic          m_valid, misalignM;
    logic          m_ready = 1'b0;
    logic [31:0]   mdataM, ALU_resultM, src2M;
    logic [PW-1:0] passM;

    mstage_lsu_if mem ();

    mstage_lsu #(.PASS_W(PW)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .ALU_resultE(ALU_resultE), .src2E(src2E), .mem_renE(mem_renE), .mem_wenE(mem_wenE),
        .funct3E(funct3E), .passE(passE), .mem(mem.master),
        .m_valid(m_valid), .m_ready(m_ready), .mdataM(mdataM), .ALU_resultM(ALU_resultM),
        .src2M(src2M), .passM(passM), .misalignM(misalignM)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int req_cnt = 0, acc_cnt = 0;

    always @(posedge clk) begin
        if (!rst) begin
            if (mem.mem_req_valid && mem.mem_req_ready) req_cnt <= req_cnt + 1;
            if (s_valid && s_ready) acc_cnt <= acc_cnt + 1;
        end
    end

    initial begin
        mem.mem_req_ready  = 1'b0;
        mem.mem_resp_valid = 1'b0;
        mem.mem_resp_rdata = '0;
    end

    // observations from the last transaction
    int            o_lat, o_nreq, o_nacc;
    logic          o_timeout, o_stable, o_req_seen;
    logic [31:0]   o_addr, o_wdata, o_mdata, o_alu, o_src2;
    logic [3:0]    o_wstrb;
    logic          o_wen, o_mis;
    logic [PW-1:0] o_pass;

    function automatic logic [PW-1:0] rand_pass();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[PW-1:0];
    endfunction

    // Reference: sizes in bytes, lanes by shifting, extension by masking.
    function automatic void model(input logic ren, input logic wen, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] src2,
                                  input logic [31:0] rdata, output logic mis, output logic req,
                                  output logic [31:0] md, output logic [3:0] ws,
                                  output logic [31:0] wd);
        int sz, o;
        logic [63:0] v, mask;
        o = int'(addr % 4);
        if (wen) sz = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        else     sz = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        mis = (ren || wen) && (o % sz != 0);
        req = (ren || wen) && !mis;
        ws = 4'd0; wd = 32'd0; md = 32'd0;
        if (wen && req) begin
            ws = 4'(((1 << sz) - 1) << o);
            wd = (sz == 1) ? 32'(src2[7:0]) * 32'h01010101 :
                 (sz == 2) ? 32'(src2[15:0]) * 32'h00010001 : src2;
        end
        if (ren && req) begin
            mask = (64'd1 << (8 * sz)) - 64'd1;
            v = (64'(rdata) >> (8 * o)) & mask;
            if ((f3 == 3'd0 || f3 == 3'd1) && v[8*sz-1]) v = v | ~mask;
            md = v[31:0];
        end
    endfunction

    task automatic run_txn(input logic ren, input logic wen, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] src2,
                           input logic [PW-1:0] pass, input logic [31:0] rdata,
                           input int dreq, input int dresp, input int dm);
        int cyc, rw, pw, r0, a0;
        o_timeout = 0; o_stable = 1; o_req_seen = 0;
        o_addr = '0; o_wdata = '0; o_wstrb = '0; o_wen = 0;
        @(negedge clk);
        r0 = req_cnt; a0 = acc_cnt;
        s_valid = 1; mem_renE = ren; mem_wenE = wen; funct3E = f3;
        ALU_resultE = addr; src2E = src2; passE = pass;
        @(negedge clk);
        s_valid = 0; ALU_resultE = $urandom; src2E = $urandom; passE = rand_pass();
        mem_renE = $urandom_range(0, 1); mem_wenE = 0; funct3E = 3'($urandom);
        cyc = 1; rw = 0; pw = 0;
        while (!m_valid && cyc < 80) begin
            if (s_ready) o_stable = 0;
            if (mem.mem_req_valid) begin
                if (!o_req_seen) begin
                    o_req_seen = 1; o_addr = mem.mem_req_addr; o_wen = mem.mem_req_wen;
                    o_wstrb = mem.mem_req_wstrb; o_wdata = mem.mem_req_wdata;
                end else if (o_addr !== mem.mem_req_addr || o_wen !== mem.mem_req_wen ||
                             o_wstrb !== mem.mem_req_wstrb || o_wdata !== mem.mem_req_wdata)
                    o_stable = 0;
                mem.mem_req_ready = (rw >= dreq); rw++;
            end else mem.mem_req_ready = 0;
            if (mem.mem_resp_ready) begin
                mem.mem_resp_valid = (pw >= dresp); mem.mem_resp_rdata = (pw >= dresp) ? rdata : $urandom;
                pw++;
            end else mem.mem_resp_valid = 0;
            @(negedge clk); cyc++;
        end
        mem.mem_req_ready = 0; mem.mem_resp_valid = 0;
        o_timeout = !m_valid;
        o_lat = cyc;
        o_mdata = mdataM; o_alu = ALU_resultM; o_src2 = src2M; o_pass = passM; o_mis = misalignM;
        for (int k = 0; k < dm; k++) begin
            @(negedge clk);
            if (!m_valid || s_ready || mdataM !== o_mdata || ALU_resultM !== o_alu ||
                src2M !== o_src2 || passM !== o_pass || misalignM !== o_mis) o_stable = 0;
        end
        m_ready = 1;
        @(negedge clk);
        m_ready = 0;
        if (m_valid || !s_ready) o_stable = 0;
        o_nreq = req_cnt - r0; o_nacc = acc_cnt - a0;
    endtask

    task automatic test_reset();
        #3;
        tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL reset_s_ready got %0b want 1", s_ready); end
        tests++; if (m_valid !== 1'b0 || mem.mem_req_valid !== 1'b0 || mem.mem_resp_ready !== 1'b0) begin
            fails++; $display("FAIL reset_valids got m%0b q%0b r%0b want 0", m_valid, mem.mem_req_valid, mem.mem_resp_ready); end
        tests++; if (mdataM !== 0 || ALU_resultM !== 0 || src2M !== 0 || passM !== 0 || misalignM !== 0) begin
            fails++; $display("FAIL reset_outputs got md=%h a=%h s=%h mis=%0b want 0", mdataM, ALU_resultM, src2M, misalignM); end
        tests++; if (mem.mem_req_addr !== 0 || mem.mem_req_wstrb !== 0 || mem.mem_req_wen !== 0) begin
            fails++; $display("FAIL reset_bus got addr=%h strb=%h wen=%0b want 0", mem.mem_req_addr, mem.mem_req_wstrb, mem.mem_req_wen); end
        @(negedge clk); rst = 0;
    endtask

    task automatic test_alu();
        logic [PW-1:0] p;
        p = rand_pass();
        run_txn(0, 0, 3'd2, 32'h1234_5677, 32'hCAFE_0001, p, 32'h0, 0, 0, 0);
        tests++; if (o_lat !== 1) begin fails++; $display("FAIL alu_latency got %0d want 1", o_lat); end
        tests++; if (o_pass !== p) begin fails++; $display("FAIL alu_passM got %h want %h", o_pass, p); end
        tests++; if (o_mdata !== 0 || o_mis !== 0) begin fails++; $display("FAIL alu_mdata got %h mis %0b want 0", o_mdata, o_mis); end
        tests++; if (o_nreq !== 0 || o_req_seen) begin fails++; $display("FAIL alu_nreq got %0d want 0", o_nreq); end
        tests++; if (o_alu !== 32'h1234_5677 || o_src2 !== 32'hCAFE_0001) begin
            fails++; $display("FAIL alu_capture got %h/%h want 12345677/cafe0001", o_alu, o_src2); end
    endtask

    task automatic test_load_byte();
        run_txn(1, 0, 3'b000, 32'h8000_0003, 32'h0, rand_pass(), 32'h80FF_1234, 0, 0, 0);
        tests++; if (o_addr !== 32'h8000_0000) begin fails++; $display("FAIL lb_addr got %h want 80000000", o_addr); end
        tests++; if (o_mdata !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_data got %h want ffffff80", o_mdata); end
        tests++; if (o_lat !== 3) begin fails++; $display("FAIL lb_latency got %0d want 3", o_lat); end
        tests++; if (o_wen !== 0 || o_wstrb !== 0) begin fails++; $display("FAIL lb_read_strb got wen=%0b strb=%h want 0", o_wen, o_wstrb); end
        run_txn(1, 0, 3'b100, 32'h8000_0003, 32'h0, rand_pass(), 32'h80FF_1234, 0, 0, 0);
        tests++; if (o_mdata !== 32'h0000_0080) begin fails++; $display("FAIL lbu_data got %h want 00000080", o_mdata); end
    endtask

    task automatic test_store_half();
        run_txn(0, 1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, rand_pass(), 32'h5555_5555, 0, 2, 0);
        tests++; if (o_wstrb !== 4'b1100) begin fails++; $display("FAIL sh_strb got %b want 1100", o_wstrb); end
        tests++; if (o_wdata !== 32'hBEEF_BEEF) begin fails++; $display("FAIL sh_wdata got %h want beefbeef", o_wdata); end
        tests++; if (o_wen !== 1 || o_nreq !== 1) begin fails++; $display("FAIL sh_req got wen=%0b n=%0d want 1/1", o_wen, o_nreq); end
        tests++; if (o_mdata !== 0 || o_lat !== 5) begin fails++; $display("FAIL sh_done got md=%h lat=%0d want 0/5", o_mdata, o_lat); end
    endtask

    task automatic test_misalign();
        run_txn(1, 0, 3'b010, 32'h8000_0006, 32'h0, rand_pass(), 32'hFFFF_FFFF, 0, 0, 0);
        tests++; if (o_mis !== 1) begin fails++; $display("FAIL lw_misalign got %0b want 1", o_mis); end
        tests++; if (o_mdata !== 0) begin fails++; $display("FAIL lw_mis_data got %h want 0", o_mdata); end
        tests++; if (o_nreq !== 0 || o_req_seen) begin fails++; $display("FAIL lw_mis_nreq got %0d want 0", o_nreq); end
        tests++; if (o_lat !== 1) begin fails++; $display("FAIL lw_mis_latency got %0d want 1", o_lat); end
    endtask

    task automatic test_stall();
        logic mis, req; logic [31:0] md, wd; logic [3:0] ws;
        model(1, 0, 3'b101, 32'h0000_1002, 32'h0, 32'h9ABC_7F01, mis, req, md, ws, wd);
        run_txn(1, 0, 3'b101, 32'h0000_1002, 32'h0, rand_pass(), 32'h9ABC_7F01, 5, 4, 3);
        tests++; if (o_stable !== 1) begin fails++; $display("FAIL stall_stable got %0b want 1", o_stable); end
        tests++; if (o_nreq !== 1 || o_nacc !== 1) begin fails++; $display("FAIL stall_counts got req=%0d acc=%0d want 1/1", o_nreq, o_nacc); end
        tests++; if (o_mdata !== md) begin fails++; $display("FAIL stall_data got %h want %h", o_mdata, md); end
        tests++; if (o_lat !== 12 || o_timeout) begin fails++; $display("FAIL stall_latency got %0d want 12", o_lat); end
    endtask

    task automatic test_random();
        logic ren, wen, mis, req; logic [2:0] f3; logic [31:0] a, s, rd, md, wd; logic [3:0] ws;
        int dq, dr, dm, sel;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 2);
            ren = (sel == 1); wen = (sel == 2);
            f3 = 3'($urandom); a = $urandom; s = $urandom; rd = $urandom;
            dq = $urandom_range(0, 3); dr = $urandom_range(0, 3); dm = $urandom_range(0, 2);
            model(ren, wen, f3, a, s, rd, mis, req, md, ws, wd);
            run_txn(ren, wen, f3, a, s, rand_pass(), rd, dq, dr, dm);
            tests++;
            if (o_timeout || !o_stable || o_mis !== mis || o_mdata !== md || o_nreq !== (req ? 1 : 0) ||
                o_lat !== (req ? 3 + dq + dr : 1) || o_alu !== a || o_src2 !== s) begin
                fails++;
                $display("FAIL rand_%0d r%0b w%0b f3=%0d a=%h got md=%h mis=%0b n=%0d lat=%0d st=%0b want md=%h mis=%0b req=%0b",
                         n, ren, wen, f3, a, o_mdata, o_mis, o_nreq, o_lat, o_stable, md, mis, req);
            end
            if (req) begin
                tests++;
                if (o_addr !== {a[31:2], 2'b00} || o_wen !== wen || o_wstrb !== ws || o_wdata !== wd) begin
                    fails++;
                    $display("FAIL rand_bus_%0d got a=%h w=%0b s=%b d=%h want a=%h w=%0b s=%b d=%h",
                             n, o_addr, o_wen, o_wstrb, o_wdata, {a[31:2], 2'b00}, wen, ws, wd);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        s_valid = 1; mem_renE = 1; mem_wenE = 0; funct3E = 3'b010;
        ALU_resultE = 32'h0000_0100; src2E = 32'h1; passE = rand_pass();
        @(negedge clk);
        s_valid = 0; mem.mem_req_ready = 1;
        @(negedge clk);
        mem.mem_req_ready = 0;
        tests++; if (mem.mem_resp_ready !== 1) begin fails++; $display("FAIL rstmid_in_resp got %0b want 1", mem.mem_resp_ready); end
        #2 rst = 1;
        #1;
        tests++; if (mem.mem_resp_ready !== 0 || m_valid !== 0 || mem.mem_req_valid !== 0 || s_ready !== 1) begin
            fails++; $display("FAIL rstmid_async got rr=%0b mv=%0b qv=%0b sr=%0b want 0/0/0/1",
                              mem.mem_resp_ready, m_valid, mem.mem_req_valid, s_ready); end
        tests++; if (passM !== 0 || ALU_resultM !== 0 || mem.mem_req_addr !== 0) begin
            fails++; $display("FAIL rstmid_regs got a=%h q=%h want 0", ALU_resultM, mem.mem_req_addr); end
        @(negedge clk);
        rst = 0; mem.mem_resp_valid = 1; mem.mem_resp_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem.mem_resp_valid = 0;
        tests++; if (mdataM !== 0 || m_valid !== 0 || s_ready !== 1) begin
            fails++; $display("FAIL rstmid_late_resp got md=%h mv=%0b sr=%0b want 0/0/1", mdataM, m_valid, s_ready); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_byte();
        test_store_half();
        test_misalign();
        test_stall();
        test_random();
        test_reset_mid();
        test_alu();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
